ctrl_seq: RTL and testbench



---
 rtl/ctrl_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_ctrl_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - instruction fetch / operand / execute / interrupt sequencer
//
// Fetches an opcode, then n = opcode[W-1:W-2] operand bytes, pulses the
// execute unit, waits for it to finish, and optionally services an
// interrupt before the next fetch. Every wait is guarded by a timeout that
// parks the sequencer in a sticky fault state until reset.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   bus_data_in  in   memory read data, valid with mem_op_done
//   mem_op_done  in   current read has completed
//   exec_done    in   execute unit finished
//   irq          in   level interrupt request
//   irq_en       in   interrupt enable
//   mem_rd       out  read request, held until done
//   pc_inc       out  one-cycle PC increment pulse
//   pc_load_vec  out  one-cycle pulse: load PC with IRQ vector
//   irq_ack      out  one-cycle interrupt acknowledge
//   exec_start   out  one-cycle execute pulse
//   opcode       out  latched opcode
//   operands     out  operand k in bits [k*W +: W]
//   fault        out  sticky fault flag

module ctrl_seq #(
   parameter int DATA_BUS_WIDTH = 8,
   parameter int MAX_OPERANDS   = 3,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic [DATA_BUS_WIDTH-1:0]              bus_data_in,
   input  logic                                   mem_op_done,
   input  logic                                   exec_done,
   input  logic                                   irq,
   input  logic                                   irq_en,
   output logic                                   mem_rd,
   output logic                                   pc_inc,
   output logic                                   pc_load_vec,
   output logic                                   irq_ack,
   output logic                                   exec_start,
   output logic [DATA_BUS_WIDTH-1:0]              opcode,
   output logic [MAX_OPERANDS*DATA_BUS_WIDTH-1:0] operands,
   output logic                                   fault
);

   localparam int W     = DATA_BUS_WIDTH;
   // At least one storage slot so the register is never zero-width.
   localparam int SLOTS = (MAX_OPERANDS == 0) ? 1 : MAX_OPERANDS;

   localparam logic [2:0] ST_FETCH     = 3'd0;
   localparam logic [2:0] ST_OPERAND   = 3'd1;
   localparam logic [2:0] ST_EXEC      = 3'd2;
   localparam logic [2:0] ST_WAIT_EXEC = 3'd3;
   localparam logic [2:0] ST_IRQ       = 3'd4;
   localparam logic [2:0] ST_FAULT     = 3'd5;

   localparam logic [2:0] MAX_N    = 3'(MAX_OPERANDS);
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [2:0]         r_state;
   logic [2:0]         w_state_next;
   // Low from reset until the first clock edge after release, so that no
   // request is issued and no done is accepted before the machine is running.
   logic               r_run;
   logic [W-1:0]       r_opcode;
   logic [SLOTS*W-1:0] r_operands;
   logic [1:0]         r_cnt;
   logic [7:0]         r_tmo;

   logic [1:0]         w_n_bus;
   logic [1:0]         w_n_op;
   logic               w_bus_n_bad;
   logic               w_last_operand;
   logic               w_mem_done;
   logic               w_exec_done;
   logic               w_waiting;
   logic               w_awaited_done;
   logic               w_timeout;

   logic               w_mem_rd;
   logic               w_pc_inc;
   logic               w_pc_load_vec;
   logic               w_irq_ack;
   logic               w_exec_start;
   logic               w_fault;

   // Operand count straight off the bus in ST_FETCH (opcode is not yet
   // latched), and from the latched opcode in ST_OPERAND.
   assign w_n_bus        = bus_data_in[W-1 -: 2];
   assign w_n_op         = r_opcode[W-1 -: 2];
   assign w_bus_n_bad    = ({1'b0, w_n_bus} > MAX_N);
   assign w_last_operand = (r_cnt == (w_n_op - 2'd1));

   // Done inputs only count in the state that is waiting for them.
   assign w_mem_done     = r_run && mem_op_done &&
                           ((r_state == ST_FETCH) || (r_state == ST_OPERAND));
   assign w_exec_done    = r_run && exec_done && (r_state == ST_WAIT_EXEC);
   assign w_waiting      = r_run && ((r_state == ST_FETCH) ||
                                     (r_state == ST_OPERAND) ||
                                     (r_state == ST_WAIT_EXEC));
   assign w_awaited_done = w_mem_done || w_exec_done;
   // A done in the last allowed cycle wins over the timeout.
   assign w_timeout      = w_waiting && !w_awaited_done && (r_tmo == TMO_LAST);

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_FETCH;
         r_run   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_run   <= 1'b1;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_FETCH: begin
            if (w_mem_done) begin
               if (w_bus_n_bad)
                  w_state_next = ST_FAULT;
               else if (w_n_bus == 2'd0)
                  w_state_next = ST_EXEC;
               else
                  w_state_next = ST_OPERAND;
            end else if (w_timeout) begin
               w_state_next = ST_FAULT;
            end
         end
         ST_OPERAND: begin
            if (w_mem_done) begin
               if (w_last_operand)
                  w_state_next = ST_EXEC;
            end else if (w_timeout) begin
               w_state_next = ST_FAULT;
            end
         end
         ST_EXEC:
            w_state_next = ST_WAIT_EXEC;
         ST_WAIT_EXEC: begin
            // irq is sampled only here, at the moment execution completes.
            if (w_exec_done)
               w_state_next = (irq && irq_en) ? ST_IRQ : ST_FETCH;
            else if (w_timeout)
               w_state_next = ST_FAULT;
         end
         ST_IRQ:
            w_state_next = ST_FETCH;
         ST_FAULT:
            w_state_next = ST_FAULT;
         default:
            w_state_next = ST_FETCH;
      endcase
   end

   // Output logic
   always_comb begin
      w_mem_rd      = 1'b0;
      w_pc_inc      = 1'b0;
      w_pc_load_vec = 1'b0;
      w_irq_ack     = 1'b0;
      w_exec_start  = 1'b0;
      w_fault       = 1'b0;
      case (r_state)
         ST_FETCH, ST_OPERAND: begin
            w_mem_rd = r_run;
            w_pc_inc = w_mem_done;
         end
         ST_EXEC:
            w_exec_start = 1'b1;
         ST_IRQ: begin
            w_pc_load_vec = 1'b1;
            w_irq_ack     = 1'b1;
         end
         ST_FAULT:
            w_fault = 1'b1;
         default: begin
         end
      endcase
   end

   assign mem_rd      = w_mem_rd;
   assign pc_inc      = w_pc_inc;
   assign pc_load_vec = w_pc_load_vec;
   assign irq_ack     = w_irq_ack;
   assign exec_start  = w_exec_start;
   assign fault       = w_fault;
   assign opcode      = r_opcode;

   // Opcode / operand capture and operand slot counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_opcode   <= '0;
         r_operands <= '0;
         r_cnt      <= 2'd0;
      end else if (w_mem_done) begin
         if (r_state == ST_FETCH) begin
            r_opcode <= bus_data_in;
            r_cnt    <= 2'd0;
         end else begin
            // Only the addressed slot is written; the rest keep old data.
            for (int k = 0; k < SLOTS; k++) begin
               if (r_cnt == 2'(k))
                  r_operands[k*W +: W] <= bus_data_in;
            end
            if (!w_last_operand)
               r_cnt <= r_cnt + 2'd1;
         end
      end
   end

   // Wait timeout counter: restarts on every done and every state change.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_tmo <= 8'd0;
      else if (w_awaited_done || (w_state_next != r_state) || !w_waiting)
         r_tmo <= 8'd0;
      else
         r_tmo <= r_tmo + 8'd1;
   end

   generate
      if (MAX_OPERANDS > 0) begin : g_operands
         assign operands = r_operands[MAX_OPERANDS*W-1:0];
      end else begin : g_no_operands
         assign operands = '0;
      end
   endgenerate

endmodule

// File: tb/tb_ctrl_seq.sv
// tb/tb_ctrl_seq.sv - randomized self-checking bench for ctrl_seq

module tb_ctrl_seq;

   logic        clock;
   logic        reset;
   logic [7:0]  bus_data_in;
   logic        mem_op_done;
   logic        exec_done;
   logic        irq;
   logic        irq_en;
   logic        mem_rd;
   logic        pc_inc;
   logic        pc_load_vec;
   logic        irq_ack;
   logic        exec_start;
   logic [7:0]  opcode;
   logic [23:0] operands;
   logic        fault;

   logic [7:0]  bus_data_in_1;
   logic        mem_op_done_1;
   logic        exec_done_1;
   logic        irq_1;
   logic        irq_en_1;
   logic        mem_rd_1;
   logic        pc_inc_1;
   logic        pc_load_vec_1;
   logic        irq_ack_1;
   logic        exec_start_1;
   logic [7:0]  opcode_1;
   logic [7:0]  operands_1;
   logic        fault_1;

   int n_vectors;
   int n_miscompares;

   int n_pc, n_exec, n_ack, n_vec, n_pc1, n_exec1;
   int exp_pc, exp_exec, exp_ack;
   logic [7:0] exp_opcode;
   logic [7:0] exp_ops [3];

   ctrl_seq #(.DATA_BUS_WIDTH(8), .MAX_OPERANDS(3), .TIMEOUT_CYCLES(15)) u_dut (
      .clock(clock), .reset(reset), .bus_data_in(bus_data_in),
      .mem_op_done(mem_op_done), .exec_done(exec_done), .irq(irq), .irq_en(irq_en),
      .mem_rd(mem_rd), .pc_inc(pc_inc), .pc_load_vec(pc_load_vec), .irq_ack(irq_ack),
      .exec_start(exec_start), .opcode(opcode), .operands(operands), .fault(fault)
   );

   ctrl_seq #(.DATA_BUS_WIDTH(8), .MAX_OPERANDS(1), .TIMEOUT_CYCLES(15)) u_dut1 (
      .clock(clock), .reset(reset), .bus_data_in(bus_data_in_1),
      .mem_op_done(mem_op_done_1), .exec_done(exec_done_1), .irq(irq_1), .irq_en(irq_en_1),
      .mem_rd(mem_rd_1), .pc_inc(pc_inc_1), .pc_load_vec(pc_load_vec_1), .irq_ack(irq_ack_1),
      .exec_start(exec_start_1), .opcode(opcode_1), .operands(operands_1), .fault(fault_1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Pulse counters, sampled mid-cycle.
   always @(negedge clock) begin
      if (pc_inc)       n_pc++;
      if (exec_start)   n_exec++;
      if (irq_ack)      n_ack++;
      if (pc_load_vec)  n_vec++;
      if (pc_inc_1)     n_pc1++;
      if (exec_start_1) n_exec1++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vectors++;
      if (got !== exp) begin
         n_miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Serve one memory read: wait for the request, stall idle cycles, answer.
   task automatic mem_xfer(input logic [7:0] data, input int idle);
      int t;
      t = 0;
      while (!mem_rd && t < 40) begin
         tick();
         t++;
      end
      if (!mem_rd) check("mem_rd_wait", mem_rd, 1);
      repeat (idle) begin
         mem_op_done = 1'b0;
         bus_data_in = 8'($urandom);
         exec_done   = 1'($urandom);
         irq         = 1'($urandom);
         irq_en      = 1'($urandom);
         tick();
      end
      mem_op_done = 1'b1;
      bus_data_in = data;
      exec_done   = 1'($urandom);
      tick();
      mem_op_done = 1'b0;
      bus_data_in = 8'($urandom);
      exec_done   = 1'b0;
      irq         = 1'b0;
      irq_en      = 1'b0;
   endtask

   // One full instruction, checked against the transaction-level model.
   task automatic run_instr(input logic [7:0] op, input logic [23:0] ops,
                            input bit irq_v, input bit en_v, input int fetch_idle);
      int n;
      int idle;
      n = int'(op[7:6]);
      mem_xfer(op, fetch_idle);
      for (int k = 0; k < n; k++)
         mem_xfer(ops[k*8 +: 8], $urandom_range(0, 5));
      check("exec_start_latency", exec_start, 1);
      check("mem_rd_in_exec", mem_rd, 0);
      tick();
      idle = $urandom_range(0, 4);
      repeat (idle) begin
         exec_done   = 1'b0;
         mem_op_done = 1'($urandom);
         bus_data_in = 8'($urandom);
         irq         = 1'($urandom);
         irq_en      = 1'($urandom);
         tick();
      end
      exec_done   = 1'b1;
      mem_op_done = 1'b0;
      irq         = irq_v;
      irq_en      = en_v;
      tick();
      exec_done = 1'b0;
      irq       = 1'b0;
      irq_en    = 1'b0;
      if (irq_v && en_v) begin
         check("irq_ack", irq_ack, 1);
         check("pc_load_vec", pc_load_vec, 1);
         check("mem_rd_in_irq", mem_rd, 0);
         tick();
      end
      check("mem_rd_refetch", mem_rd, 1);

      exp_pc   += 1 + n;
      exp_exec += 1;
      if (irq_v && en_v) exp_ack += 1;
      for (int k = 0; k < n; k++)
         exp_ops[k] = ops[k*8 +: 8];
      exp_opcode = op;

      check("opcode", opcode, exp_opcode);
      check("operands", operands, {exp_ops[2], exp_ops[1], exp_ops[0]});
      check("pc_inc_count", n_pc, exp_pc);
      check("exec_start_count", n_exec, exp_exec);
      check("irq_ack_count", n_ack, exp_ack);
      check("pc_load_vec_count", n_vec, exp_ack);
      check("fault_clear", fault, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vectors = 0; n_miscompares = 0;
      n_pc = 0; n_exec = 0; n_ack = 0; n_vec = 0; n_pc1 = 0; n_exec1 = 0;
      exp_pc = 0; exp_exec = 0; exp_ack = 0; exp_opcode = 8'h00;
      for (int k = 0; k < 3; k++) exp_ops[k] = 8'h00;

      reset = 1'b1;
      bus_data_in = 8'h00; mem_op_done = 1'b1; exec_done = 1'b0; irq = 1'b0; irq_en = 1'b0;
      bus_data_in_1 = 8'h00; mem_op_done_1 = 1'b0; exec_done_1 = 1'b0; irq_1 = 1'b0; irq_en_1 = 1'b0;
      tick();
      tick();
      check("rst_mem_rd", mem_rd, 0);
      check("rst_pc_inc", pc_inc, 0);
      check("rst_fault", fault, 0);
      check("rst_opcode", opcode, 0);
      check("rst_operands", operands, 0);
      check("rst_exec_start", exec_start, 0);
      check("rst_irq_ack", irq_ack, 0);
      check("rst_mem_rd_1", mem_rd_1, 0);

      reset = 1'b0;
      mem_op_done = 1'b0;
      #1;
      check("mem_rd_before_first_edge", mem_rd, 0);
      tick();
      check("mem_rd_after_first_edge", mem_rd, 1);

      // One-operand build: opcode with n=3 must fault without executing.
      mem_op_done_1 = 1'b1;
      bus_data_in_1 = 8'hC0;
      tick();
      mem_op_done_1 = 1'b0;
      check("max1_fault", fault_1, 1);
      check("max1_mem_rd", mem_rd_1, 0);
      check("max1_opcode", opcode_1, 8'hC0);
      repeat (3) tick();
      check("max1_no_exec", n_exec1, 0);
      check("max1_pc_inc", n_pc1, 1);
      check("max1_fault_sticky", fault_1, 1);

      reset = 1'b1;
      #1;
      check("rst_clears_fault_1", fault_1, 0);
      tick();
      reset = 1'b0;
      tick();

      // Directed cases, then random instructions.
      run_instr(8'h80, 24'h00_22_11, 1'b0, 1'b0, 1);
      run_instr(8'h05, 24'h0, 1'b0, 1'b0, 0);
      run_instr(8'h05, 24'h0, 1'b1, 1'b1, 0);
      run_instr(8'h05, 24'h0, 1'b1, 1'b0, 2);
      for (int i = 0; i < 24; i++)
         run_instr(8'($urandom), 24'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 5));

      // Reset in the middle of an operand fetch.
      mem_xfer(8'hC0, 0);
      mem_xfer(8'hAB, 1);
      check("mid_operand_mem_rd", mem_rd, 1);
      reset = 1'b1;
      mem_op_done = 1'b1;
      bus_data_in = 8'h77;
      #1;
      check("async_rst_mem_rd", mem_rd, 0);
      check("async_rst_pc_inc", pc_inc, 0);
      check("async_rst_opcode", opcode, 0);
      check("async_rst_operands", operands, 0);
      check("async_rst_exec_start", exec_start, 0);
      tick();
      reset = 1'b0;
      mem_op_done = 1'b0;
      #1;
      check("post_rst_mem_rd_low", mem_rd, 0);
      tick();
      check("post_rst_mem_rd_high", mem_rd, 1);
      exp_pc += 2;
      exp_opcode = 8'h00;
      for (int k = 0; k < 3; k++) exp_ops[k] = 8'h00;
      check("post_rst_pc_inc_count", n_pc, exp_pc);
      run_instr(8'h41, 24'h00_00_5A, 1'b0, 1'b0, 0);

      // Done arriving on the last allowed cycle wins.
      run_instr(8'h05, 24'h0, 1'b0, 1'b0, 14);

      // No done for the full window: fault.
      repeat (14) begin
         mem_op_done = 1'b0;
         exec_done = 1'($urandom);
         tick();
      end
      check("tmo_no_fault_yet", fault, 0);
      check("tmo_mem_rd_still", mem_rd, 1);
      exec_done = 1'b0;
      tick();
      check("tmo_fault", fault, 1);
      check("tmo_mem_rd_dropped", mem_rd, 0);
      mem_op_done = 1'b1;
      #1;
      check("fault_pc_inc", pc_inc, 0);
      tick();
      mem_op_done = 1'b0;
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      check("fault_sticky", fault, 1);
      check("fault_exec_count", n_exec, exp_exec);
      check("fault_pc_count", n_pc, exp_pc);

      reset = 1'b1;
      #1;
      check("rst_clears_fault", fault, 0);
      tick();
      reset = 1'b0;
      tick();
      check("final_mem_rd", mem_rd, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
